// File: rtl/key_led_sequencer.sv
// Two-key LED lab controller: debounced key[0] steps through OFF/COUNT/CHASE/BOUNCE,
// key[1] pauses and resumes the running pattern. All outputs are registered.
module key_led_sequencer #(
   parameter int NUM_LEDS = 10,
   parameter int DEBOUNCE = 4,
   parameter int STEP     = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [1:0]          key,
   output logic [NUM_LEDS-1:0] led,
   output logic [1:0]          mode,
   output logic                paused
);

   localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
   localparam int TW = (STEP > 1) ? $clog2(STEP) : 1;
   localparam logic [CW-1:0]       CNT_LAST   = CW'(DEBOUNCE - 1);
   localparam logic [TW-1:0]       TIMER_LAST = TW'(STEP - 1);
   localparam logic [NUM_LEDS-1:0] LED_ONE    = {{(NUM_LEDS-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      MODE_OFF    = 2'd0,
      MODE_COUNT  = 2'd1,
      MODE_CHASE  = 2'd2,
      MODE_BOUNCE = 2'd3
   } mode_t;

   logic [1:0]    sync_q;
   logic [1:0]    stable_q;
   logic [1:0]    press_q;
   logic [CW-1:0] cnt_q [2];

   // The press pulse is raised on the same edge that stable rises, so it is
   // visible during the following cycle only.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q   <= '0;
         stable_q <= '0;
         press_q  <= '0;
         for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
      end else begin
         sync_q <= key;
         for (int i = 0; i < 2; i++) begin
            press_q[i] <= 1'b0;
            if (sync_q[i] != stable_q[i]) begin
               if (cnt_q[i] == CNT_LAST) begin
                  stable_q[i] <= sync_q[i];
                  cnt_q[i]    <= '0;
                  press_q[i]  <= sync_q[i];
               end else begin
                  cnt_q[i] <= cnt_q[i] + 1'b1;
               end
            end else begin
               cnt_q[i] <= '0;
            end
         end
      end
   end

   mode_t               state_q, state_d;
   logic [NUM_LEDS-1:0] led_q, led_d;
   logic                paused_q, paused_d;
   logic                dir_q, dir_d;
   logic [TW-1:0]       timer_q, timer_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= MODE_OFF;
         led_q    <= '0;
         paused_q <= 1'b0;
         dir_q    <= 1'b0;
         timer_q  <= '0;
      end else begin
         state_q  <= state_d;
         led_q    <= led_d;
         paused_q <= paused_d;
         dir_q    <= dir_d;
         timer_q  <= timer_d;
      end
   end

   // Priority: mode press, then pause toggle, then pattern stepping.
   always_comb begin
      state_d  = state_q;
      led_d    = led_q;
      paused_d = paused_q;
      dir_d    = dir_q;
      timer_d  = timer_q;
      if (press_q[0]) begin
         state_d  = mode_t'(state_q + 2'd1);
         paused_d = 1'b0;
         timer_d  = '0;
         dir_d    = 1'b0;
         led_d    = (state_d == MODE_CHASE || state_d == MODE_BOUNCE) ? LED_ONE : '0;
      end else if (press_q[1] && state_q != MODE_OFF) begin
         paused_d = ~paused_q;
         // Resuming restarts the step so the next advance is a full STEP away.
         timer_d  = paused_q ? '0 : timer_q;
      end else if (!paused_q && state_q != MODE_OFF) begin
         if (timer_q == TIMER_LAST) begin
            timer_d = '0;
            case (state_q)
               MODE_COUNT: led_d = led_q + 1'b1;
               MODE_CHASE: led_d = {led_q[NUM_LEDS-2:0], led_q[NUM_LEDS-1]};
               MODE_BOUNCE: begin
                  if (!dir_q) begin
                     led_d = led_q << 1;
                     if (led_q[NUM_LEDS-2]) dir_d = 1'b1;
                  end else begin
                     led_d = led_q >> 1;
                     if (led_q[1]) dir_d = 1'b0;
                  end
               end
               default: led_d = led_q;
            endcase
         end else begin
            timer_d = timer_q + 1'b1;
         end
      end
   end

   assign led    = led_q;
   assign mode   = state_q;
   assign paused = paused_q;

endmodule

// File: tb/tb_key_led_sequencer.sv
// Directed bench for key_led_sequencer: two instances share keys and reset,
// STEP=2 for the COUNT checks and STEP=1 for CHASE/BOUNCE.
module tb_key_led_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] key;
   logic [3:0] led1, led2;
   logic [1:0] mode1, mode2;
   logic       paused1, paused2;
   int         n_vec = 0;
   int         n_err = 0;
   logic [3:0] exp_q[$];

   always #5 clk = ~clk;

   key_led_sequencer #(.NUM_LEDS(4), .DEBOUNCE(4), .STEP(1)) dut_s1 (
      .clk(clk), .rst(rst), .key(key), .led(led1), .mode(mode1), .paused(paused1)
   );

   key_led_sequencer #(.NUM_LEDS(4), .DEBOUNCE(4), .STEP(2)) dut_s2 (
      .clk(clk), .rst(rst), .key(key), .led(led2), .mode(mode2), .paused(paused2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   // Key raised just after edge e takes effect on the outputs at edge e+6.
   task automatic press(input logic [1:0] k);
      key = k;
      idle(6);
      key = 2'b00;
   endtask

   initial begin
      rst = 1'b1;
      key = 2'b11;
      idle(3);
      check("rst_led", led2, 0);
      check("rst_mode", mode2, 0);
      check("rst_paused", paused2, 0);

      // Both keys held through reset: one simultaneous press, mode wins.
      rst = 1'b0;
      idle(5);
      check("held_key_early", mode2, 0);
      tick();
      check("held_key_mode", mode2, 1);
      check("held_key_paused", paused2, 0);
      key = 2'b00;
      idle(6);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst2_mode", mode2, 0);

      for (int r = 0; r < 5; r++) begin
         key = 2'b01;
         idle(3);
         key = 2'b00;
         idle(3);
         check("glitch_mode", mode2, 0);
      end
      key = 2'b01;
      idle(4);
      key = 2'b00;
      tick();
      check("deb4_early", mode2, 0);
      tick();
      check("deb4_mode", mode2, 1);
      idle(6);
      key = 2'b01;
      idle(200);
      check("hold_mode", mode2, 2);
      key = 2'b00;
      idle(8);
      check("hold_release_mode", mode2, 2);

      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst3_mode", mode2, 0);
      check("rst3_led", led2, 0);

      // COUNT with STEP=2, wrapping past 15, then pause at 5.
      press(2'b01);
      check("count_mode", mode2, 1);
      check("count_led0", led2, 0);
      for (int n = 1; n <= 42; n++) begin
         tick();
         check("count_led", led2, (n / 2) % 16);
         if (n == 37) key = 2'b10;
      end
      tick();
      key = 2'b00;
      check("pause_flag", paused2, 1);
      check("pause_led", led2, 5);
      for (int k = 0; k < 5; k++) begin
         idle(10);
         check("pause_hold", led2, 5);
      end
      press(2'b10);
      check("resume_flag", paused2, 0);
      check("resume_led0", led2, 5);
      tick();
      check("resume_led1", led2, 5);
      tick();
      check("resume_led2", led2, 6);

      idle(2);
      press(2'b01);
      check("chase_mode", mode1, 2);
      check("chase_led0", led1, 1);
      check("chase_paused", paused1, 0);
      exp_q = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
      while (exp_q.size() > 0) begin
         tick();
         check("chase_led", led1, exp_q.pop_front());
      end

      idle(2);
      press(2'b01);
      check("bounce_mode", mode1, 3);
      check("bounce_led0", led1, 1);
      exp_q = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
      while (exp_q.size() > 0) begin
         tick();
         check("bounce_led", led1, exp_q.pop_front());
      end

      press(2'b01);
      check("off_mode", mode1, 0);
      check("off_led", led1, 0);
      for (int m = 1; m <= 4; m++) begin
         idle(6);
         press(2'b01);
         check("wrap_mode", mode1, m % 4);
      end
      check("wrap_off_led1", led1, 0);
      check("wrap_off_led2", led2, 0);
      idle(6);
      press(2'b10);
      check("off_pause_ignored", paused1, 0);

      idle(6);
      press(2'b01);
      idle(6);
      press(2'b01);
      check("simul_pre_mode", mode1, 2);
      press(2'b10);
      check("simul_pre_paused", paused1, 1);
      idle(6);
      press(2'b11);
      check("simul_mode", mode1, 3);
      check("simul_paused", paused1, 0);
      check("simul_led1", led1, 4'b0001);
      check("simul_led2", led2, 4'b0001);

      // Pause BOUNCE while it is on its way down.
      idle(5);
      key = 2'b10;
      idle(6);
      key = 2'b00;
      check("bdown_led", led1, 4'b0100);
      check("bdown_paused", paused1, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_led", led1, 0);
      check("midrst_mode", mode1, 0);
      check("midrst_paused", paused1, 0);
      press(2'b10);
      check("midrst_off_pause", paused1, 0);
      check("midrst_off_mode", mode1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
